// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one bus controller between NUM_REQ masters,
// one transaction in flight, bounded same-master bursts.
//
// state | meaning
// ARB   | idle; pick next requester round-robin after the last winner
// ISSUE | drive bus from granted master, pulse its req_ready
// WAIT  | read in flight; capture bus_rdata on the last wait cycle
// RESP  | pulse rsp_valid; continue burst or return to ARB
module bus_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1,
    parameter int MAX_BURST  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         bus_we,
    output logic [ADDR_W-1:0]            bus_addr,
    output logic [DATA_W-1:0]            bus_wdata,
    input  logic [DATA_W-1:0]            bus_rdata,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(RD_LATENCY - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [GW-1:0] LAST_RST = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {ARB, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     last_q, last_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic [CW-1:0]     wait_q, wait_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [GW-1:0]     winner;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;

    // Scan farthest-to-nearest so the nearest requester after last_q wins.
    always_comb begin
        int idx;
        idx    = 0;
        winner = last_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            if (req_valid[idx]) winner = GW'(idx);
        end
    end

    always_comb begin
        g_we    = req_we[grant_q];
        g_addr  = req_addr[int'(grant_q)*ADDR_W +: ADDR_W];
        g_wdata = req_wdata[int'(grant_q)*DATA_W +: DATA_W];
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        bus_we    = 1'b0;
        bus_addr  = addr_q;
        bus_wdata = wdata_q;
        if (state_q == ISSUE) begin
            req_ready[grant_q] = 1'b1;
            bus_we             = g_we;
            bus_addr           = g_addr;
            bus_wdata          = g_wdata;
        end
        if (state_q == RESP) rsp_valid[grant_q] = 1'b1;
    end

    assign rsp_rdata = rdata_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != ARB);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        burst_d = burst_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            ARB: begin
                if (|req_valid) begin
                    grant_d = winner;
                    last_d  = winner;
                    burst_d = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                addr_d  = g_addr;
                wdata_d = g_wdata;
                wait_d  = WAIT_LOAD;
                state_d = g_we ? RESP : WAIT;
            end
            WAIT: begin
                if (wait_q == '0) begin
                    rdata_d = bus_rdata;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            RESP: begin
                if (req_valid[grant_q] && (burst_q < BURST_LAST)) begin
                    burst_d = burst_q + 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB;
            grant_q <= '0;
            last_q  <= LAST_RST;
            burst_q <= '0;
            wait_q  <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus a randomized run checked
// against a transaction-timeline reference model.
`timescale 1ns/1ps
module tb_bus_arbiter;
    localparam int NUM_REQ    = 2;
    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 8;
    localparam int RD_LATENCY = 1;
    localparam int MAX_BURST  = 4;
    localparam int GW         = $clog2(NUM_REQ);

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NUM_REQ-1:0]         req_valid, req_we, req_ready, rsp_valid;
    logic [NUM_REQ*ADDR_W-1:0]  req_addr;
    logic [NUM_REQ*DATA_W-1:0]  req_wdata;
    logic [DATA_W-1:0]          rsp_rdata, bus_wdata, bus_rdata;
    logic                       bus_we, busy;
    logic [ADDR_W-1:0]          bus_addr;
    logic [GW-1:0]              grant_id;

    int checks = 0;
    int failures = 0;
    int last_grant;
    logic [ADDR_W-1:0] last_addr;

    always #5 clk = ~clk;

    bus_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .RD_LATENCY(RD_LATENCY), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .grant_id(grant_id), .busy(busy)
    );

    function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ a[15:8] ^ {7'b0, a[16]} ^ 8'h2C;
    endfunction

    function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] v);
        for (int k = 1; k <= NUM_REQ; k++)
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        return -1;
    endfunction

    // Bus controller model: read data appears RD_LATENCY cycles after the issue cycle.
    logic              hist_v [RD_LATENCY];
    logic [ADDR_W-1:0] hist_a [RD_LATENCY];
    initial begin
        for (int i = 0; i < RD_LATENCY; i++) begin
            hist_v[i] = 1'b0;
            hist_a[i] = '0;
        end
        bus_rdata = '0;
        forever begin
            @(negedge clk);
            bus_rdata = hist_v[RD_LATENCY-1] ? mem_rd(hist_a[RD_LATENCY-1]) : DATA_W'($urandom);
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                hist_v[i] = hist_v[i-1];
                hist_a[i] = hist_a[i-1];
            end
            hist_v[0] = (req_ready != '0) && !bus_we;
            hist_a[0] = bus_addr;
        end
    end

    task automatic drive_pt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        drive_pt();
        drive_pt();
        reset = 1'b1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            drive_pt();
        end
        drive_pt();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, bus_we, busy, grant_id, bus_addr, bus_wdata, rsp_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b rsp=%b we=%b busy=%b gid=%0d addr=%h wd=%h rd=%h exp all 0",
                     req_ready, rsp_valid, bus_we, busy, grant_id, bus_addr, bus_wdata, rsp_rdata);
        end
        drive_pt();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req_ready !== '0) begin
            failures++;
            $display("FAIL reset_release got busy=%b ready=%b exp 0 0", busy, req_ready);
        end
        drive_pt();
    endtask

    task automatic test_single_write();
        req_valid = 2'b10;
        req_we    = 2'b10;
        req_addr[ADDR_W +: ADDR_W]  = 17'h10004;
        req_wdata[DATA_W +: DATA_W] = 8'hA5;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL wr_arb got ready=%b busy=%b exp 00 0", req_ready, busy);
        end
        drive_pt();
        @(negedge clk);
        checks++;
        if ({bus_we, bus_addr, bus_wdata, req_ready} !== {1'b1, 17'h10004, 8'hA5, 2'b10}) begin
            failures++;
            $display("FAIL wr_issue got we=%b addr=%h wd=%h ready=%b exp 1 10004 a5 10",
                     bus_we, bus_addr, bus_wdata, req_ready);
        end
        checks++;
        if (rsp_valid !== 2'b00 || busy !== 1'b1) begin
            failures++;
            $display("FAIL wr_issue_rsp got rsp=%b busy=%b exp 00 1", rsp_valid, busy);
        end
        drive_pt();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b10 || req_ready !== 2'b00 || bus_we !== 1'b0) begin
            failures++;
            $display("FAIL wr_resp got rsp=%b ready=%b we=%b exp 10 00 0", rsp_valid, req_ready, bus_we);
        end
        drive_pt();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 17'h10004 || grant_id !== GW'(1)) begin
            failures++;
            $display("FAIL wr_after got rsp=%b busy=%b we=%b addr=%h gid=%0d exp 00 0 0 10004 1",
                     rsp_valid, busy, bus_we, bus_addr, grant_id);
        end
        drive_pt();
    endtask

    task automatic test_single_read();
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr[0 +: ADDR_W] = 17'h00010;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00) begin
            failures++;
            $display("FAIL rd_arb got ready=%b exp 00", req_ready);
        end
        drive_pt();
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01 || bus_we !== 1'b0 || bus_addr !== 17'h00010) begin
            failures++;
            $display("FAIL rd_issue got ready=%b we=%b addr=%h exp 01 0 00010", req_ready, bus_we, bus_addr);
        end
        drive_pt();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || bus_we !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rd_wait got ready=%b rsp=%b we=%b busy=%b exp 00 00 0 1", req_ready, rsp_valid, bus_we, busy);
        end
        drive_pt();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== 8'h3C || bus_we !== 1'b0) begin
            failures++;
            $display("FAIL rd_resp got rsp=%b rdata=%h we=%b exp 01 3c 0", rsp_valid, rsp_rdata, bus_we);
        end
        drive_pt();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rd_after got rsp=%b busy=%b exp 00 0", rsp_valid, busy);
        end
        drive_pt();
    endtask

    // Each master drops its request for one cycle after acceptance, forcing re-arbitration.
    task automatic test_round_robin();
        int rem[NUM_REQ];
        bit cool[NUM_REQ];
        int rsp_cnt[NUM_REQ];
        int order[$];
        int cyc;
        bit ok;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            rem[i] = 3;
            cool[i] = 1'b0;
            rsp_cnt[i] = 0;
        end
        cyc = 0;
        while ((rsp_cnt[0] + rsp_cnt[1] < 6) && cyc < 100) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_valid[i] = (rem[i] > 0) && !cool[i];
                req_we[i]    = 1'b1;
                req_addr[i*ADDR_W +: ADDR_W]  = ADDR_W'(i*256 + rem[i]);
                req_wdata[i*DATA_W +: DATA_W] = DATA_W'(8'h10 + i*16 + rem[i]);
            end
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                cool[i] = req_ready[i];
                if (req_ready[i]) begin
                    order.push_back(i);
                    rem[i]--;
                end
                if (rsp_valid[i]) rsp_cnt[i]++;
            end
            drive_pt();
            cyc++;
        end
        idle_inputs();
        checks++;
        if (order.size() != 6) begin
            failures++;
            $display("FAIL rr_grants got %0d grants exp 6 (cycles=%0d)", order.size(), cyc);
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (order[k] != k % 2) begin
                    failures++;
                    $display("FAIL rr_order[%0d] got %0d exp %0d", k, order[k], k % 2);
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            checks++;
            if (rsp_cnt[i] != 3) begin
                failures++;
                $display("FAIL rr_rsp_count[%0d] got %0d exp 3", i, rsp_cnt[i]);
            end
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rr_drain got busy=%b exp 0 within bound", busy);
        end
    endtask

    task automatic test_burst();
        int rem[NUM_REQ];
        int order[$];
        int rc[$];
        int exp_ord[7];
        int exp_gap[4];
        int cyc;
        bit ok;
        exp_ord = '{0, 0, 0, 0, 1, 0, 0};
        exp_gap = '{2, 2, 2, 3};
        rem[0] = 6;
        rem[1] = 1;
        cyc = 0;
        while (order.size() < 7 && cyc < 200) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_valid[i] = (rem[i] > 0);
                req_we[i]    = 1'b1;
                req_addr[i*ADDR_W +: ADDR_W]  = ADDR_W'(i*256 + rem[i]);
                req_wdata[i*DATA_W +: DATA_W] = DATA_W'(8'h40 + i*16 + rem[i]);
            end
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    order.push_back(i);
                    rc.push_back(cyc);
                    last_grant = i;
                    last_addr  = ADDR_W'(i*256 + rem[i]);
                    rem[i]--;
                end
            end
            drive_pt();
            cyc++;
        end
        idle_inputs();
        checks++;
        if (order.size() != 7) begin
            failures++;
            $display("FAIL burst_grants got %0d grants exp 7", order.size());
        end else begin
            for (int k = 0; k < 7; k++) begin
                checks++;
                if (order[k] != exp_ord[k]) begin
                    failures++;
                    $display("FAIL burst_order[%0d] got %0d exp %0d", k, order[k], exp_ord[k]);
                end
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (rc[k+1] - rc[k] != exp_gap[k]) begin
                    failures++;
                    $display("FAIL burst_gap[%0d] got %0d exp %0d", k, rc[k+1] - rc[k], exp_gap[k]);
                end
            end
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL burst_drain got busy=%b exp 0 within bound", busy);
        end
    endtask

    task automatic test_idle();
        bit got[NUM_REQ];
        int first;
        bit ok;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, bus_we, req_ready, rsp_valid} !== '0) begin
                failures++;
                $display("FAIL idle_quiet got busy=%b we=%b ready=%b rsp=%b exp all 0", busy, bus_we, req_ready, rsp_valid);
            end
            checks++;
            if (grant_id !== GW'(last_grant) || bus_addr !== last_addr) begin
                failures++;
                $display("FAIL idle_hold got gid=%0d addr=%h exp %0d %h", grant_id, bus_addr, last_grant, last_addr);
            end
            drive_pt();
        end
        first = -1;
        got[0] = 1'b0;
        got[1] = 1'b0;
        req_we = 2'b11;
        for (int c = 0; c < 30 && !(got[0] && got[1]); c++) begin
            for (int i = 0; i < NUM_REQ; i++) req_valid[i] = !got[i];
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    got[i] = 1'b1;
                    if (first < 0) first = i;
                end
            end
            drive_pt();
        end
        idle_inputs();
        checks++;
        if (first != (last_grant + 1) % NUM_REQ) begin
            failures++;
            $display("FAIL idle_next_grant got %0d exp %0d", first, (last_grant + 1) % NUM_REQ);
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL idle_drain got busy=%b exp 0 within bound", busy);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [NUM_REQ-1:0] first;
        bit got1;
        bit ok;
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr[0 +: ADDR_W] = 17'h1ABCD;
        @(negedge clk);
        drive_pt();
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL mrst_issue got ready=%b exp 01", req_ready);
        end
        drive_pt();
        idle_inputs();
        reset = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, bus_we, busy, grant_id, bus_addr, bus_wdata, rsp_rdata} !== '0) begin
            failures++;
            $display("FAIL mrst_outputs got ready=%b rsp=%b we=%b busy=%b gid=%0d addr=%h wd=%h rd=%h exp all 0",
                     req_ready, rsp_valid, bus_we, busy, grant_id, bus_addr, bus_wdata, rsp_rdata);
        end
        req_valid = 2'b11;
        req_we    = 2'b11;
        req_addr  = {17'h00222, 17'h00111};
        req_wdata = {8'h22, 8'h11};
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
                failures++;
                $display("FAIL mrst_held got rsp=%b ready=%b exp 00 00", rsp_valid, req_ready);
            end
            drive_pt();
        end
        reset = 1'b1;
        first = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 2'b00) begin
                failures++;
                $display("FAIL mrst_stale_rsp got rsp=%b exp 00", rsp_valid);
            end
            if (req_ready != '0) begin
                first = req_ready;
                break;
            end
            drive_pt();
        end
        checks++;
        if (first !== 2'b01) begin
            failures++;
            $display("FAIL mrst_first_grant got ready=%b exp 01", first);
        end
        drive_pt();
        req_valid[0] = 1'b0;
        got1 = 1'b0;
        for (int c = 0; c < 20 && !got1; c++) begin
            @(negedge clk);
            if (req_ready[1]) got1 = 1'b1;
            drive_pt();
        end
        idle_inputs();
        wait_idle(ok);
        checks++;
        if (!got1 || !ok) begin
            failures++;
            $display("FAIL mrst_second got served=%b idle=%b exp 1 1", got1, ok);
        end
    endtask

    // Reference model: tracks the granted master and the cycles at which its
    // next issue and response are due; arbitration happens only when no grant is held.
    task automatic test_random();
        bit pend[NUM_REQ];
        bit m_act;
        int m_g, m_last, m_n, m_issue, m_rsp;
        bit m_rd;
        logic [DATA_W-1:0] m_rdata, m_hwd, e_wd;
        logic [ADDR_W-1:0] m_haddr, e_addr;
        logic [NUM_REQ-1:0] e_ready, e_rsp;
        logic e_we, e_busy;
        logic [GW-1:0] e_grant;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
        m_act = 1'b0; m_g = 0; m_last = NUM_REQ - 1; m_n = 0;
        m_issue = -1; m_rsp = -1; m_rd = 1'b0;
        m_rdata = '0; m_haddr = '0; m_hwd = '0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && cyc < 600 && $urandom_range(0, 3) != 0) begin
                    pend[i] = 1'b1;
                    req_we[i] = 1'($urandom_range(0, 1));
                    req_addr[i*ADDR_W +: ADDR_W]  = ADDR_W'($urandom);
                    req_wdata[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                end
                req_valid[i] = pend[i];
            end
            @(negedge clk);
            e_ready = '0; e_rsp = '0; e_we = 1'b0;
            e_addr = m_haddr; e_wd = m_hwd; e_busy = m_act; e_grant = GW'(m_g);
            if (!m_act) begin
                if (req_valid != '0) begin
                    m_g = rr_pick(m_last, req_valid);
                    m_last = m_g;
                    m_act = 1'b1;
                    m_n = 0;
                    m_issue = cyc + 1;
                end
            end else if (cyc == m_issue) begin
                e_ready[m_g] = 1'b1;
                e_we   = req_we[m_g];
                e_addr = req_addr[m_g*ADDR_W +: ADDR_W];
                e_wd   = req_wdata[m_g*DATA_W +: DATA_W];
                m_haddr = e_addr;
                m_hwd   = e_wd;
                m_n++;
                m_rd = !e_we;
                m_rdata = mem_rd(e_addr);
                m_rsp = cyc + 1 + (m_rd ? RD_LATENCY : 0);
            end else if (cyc == m_rsp) begin
                e_rsp[m_g] = 1'b1;
                if (req_valid[m_g] && m_n < MAX_BURST) m_issue = cyc + 1;
                else m_act = 1'b0;
            end
            checks++;
            if ({req_ready, rsp_valid} !== {e_ready, e_rsp}) begin
                failures++;
                $display("FAIL rnd_handshake cyc=%0d got ready=%b rsp=%b exp %b %b", cyc, req_ready, rsp_valid, e_ready, e_rsp);
            end
            checks++;
            if ({bus_we, bus_addr, bus_wdata} !== {e_we, e_addr, e_wd}) begin
                failures++;
                $display("FAIL rnd_bus cyc=%0d got we=%b addr=%h wd=%h exp %b %h %h", cyc, bus_we, bus_addr, bus_wdata, e_we, e_addr, e_wd);
            end
            checks++;
            if ({busy, grant_id} !== {e_busy, e_grant}) begin
                failures++;
                $display("FAIL rnd_status cyc=%0d got busy=%b gid=%0d exp %b %0d", cyc, busy, grant_id, e_busy, e_grant);
            end
            if (e_rsp != '0 && m_rd) begin
                checks++;
                if (rsp_rdata !== m_rdata) begin
                    failures++;
                    $display("FAIL rnd_rdata cyc=%0d got %h exp %h", cyc, rsp_rdata, m_rdata);
                end
            end
            for (int i = 0; i < NUM_REQ; i++)
                if (req_ready[i]) pend[i] = 1'b0;
            drive_pt();
        end
        checks++;
        if (pend[0] || pend[1] || m_act || busy !== 1'b0) begin
            failures++;
            $display("FAIL rnd_drain got pend=%b%b model_busy=%b busy=%b exp all 0", pend[1], pend[0], m_act, busy);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        last_grant = 0;
        last_addr = '0;
        test_reset();
        test_single_write();
        test_single_read();
        test_round_robin();
        test_burst();
        test_idle();
        test_reset_mid_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
